// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - 800x480 panel timing constants and shared types for the LCD timing driver
package lcd_timing_pkg;

  localparam int unsigned LCD_H_SYNC  = 128;
  localparam int unsigned LCD_H_BACK  = 88;
  localparam int unsigned LCD_H_VALID = 800;
  localparam int unsigned LCD_H_FRONT = 40;
  localparam int unsigned LCD_H_TOTAL = LCD_H_SYNC + LCD_H_BACK + LCD_H_VALID + LCD_H_FRONT;

  localparam int unsigned LCD_V_SYNC  = 2;
  localparam int unsigned LCD_V_BACK  = 33;
  localparam int unsigned LCD_V_VALID = 480;
  localparam int unsigned LCD_V_FRONT = 10;
  localparam int unsigned LCD_V_TOTAL = LCD_V_SYNC + LCD_V_BACK + LCD_V_VALID + LCD_V_FRONT;

  localparam int unsigned RGB_W = 24;
  localparam int unsigned PIX_W = 10;
  localparam int unsigned H_W   = 11;
  localparam int unsigned V_W   = 10;

  // Coordinate value presented to the pattern source outside the active area
  localparam logic [PIX_W-1:0] PIX_NONE = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } lcd_state_t;

endpackage

// File: rtl/lcd_sync_delay.sv
// rtl/lcd_sync_delay.sv - fixed-depth shift register that matches control flags to the pattern source latency
module lcd_sync_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] sr [DEPTH];

      // Shift the flags one stage per clock; reset clears every stage so no stale pulse escapes
      always_ff @(posedge clk_in) begin
        if (sys_rst) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lcd_timing_drv.sv
// rtl/lcd_timing_drv.sv - parallel-RGB LCD timing driver: counters, sync/DE generation, pixel request and output stage
module lcd_timing_drv
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = LCD_H_SYNC,
  parameter int unsigned H_BACK   = LCD_H_BACK,
  parameter int unsigned H_VALID  = LCD_H_VALID,
  parameter int unsigned H_FRONT  = LCD_H_FRONT,
  parameter int unsigned V_SYNC   = LCD_V_SYNC,
  parameter int unsigned V_BACK   = LCD_V_BACK,
  parameter int unsigned V_VALID  = LCD_V_VALID,
  parameter int unsigned V_FRONT  = LCD_V_FRONT,
  parameter int unsigned PIC_LAT  = 1,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk_in,
  input  logic             sys_rst,
  input  logic             lcd_en,
  input  logic [RGB_W-1:0] pix_data,
  output logic [PIX_W-1:0] pix_x,
  output logic [PIX_W-1:0] pix_y,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [RGB_W-1:0] lcd_rgb,
  output logic             frame_start,
  output logic             busy
);

  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_SYNC);
  localparam logic [H_W-1:0] H_ACT0     = H_W'(H_SYNC + H_BACK);
  localparam logic [H_W-1:0] H_ACT1     = H_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [H_W-1:0] H_LAST     = H_W'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_SYNC);
  localparam logic [V_W-1:0] V_ACT0     = V_W'(V_SYNC + V_BACK);
  localparam logic [V_W-1:0] V_ACT1     = V_W'(V_SYNC + V_BACK + V_VALID);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam logic           SYNC_IDLE  = ~SYNC_POL;

  lcd_state_t state, state_nxt;

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           h_last, v_last, frame_last, running;
  logic           hs_c, vs_c, act_c, fs_c;
  logic           act_1, hs_1, vs_1, fs_1;
  logic           act_d, hs_d, vs_d, fs_d;

  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_last = h_last && v_last;
  assign running    = (state != ST_IDLE);
  assign busy       = running;

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state: start on request, stop only once the frame in flight has completed
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (lcd_en) state_nxt = ST_RUN;
      ST_RUN:  if (!lcd_en) state_nxt = frame_last ? ST_IDLE : ST_STOP;
      ST_STOP: begin
        if (lcd_en)          state_nxt = ST_RUN;
        else if (frame_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Raster counters; parked at 0 while idle so a new run begins at h = v = 0
  always_ff @(posedge clk_in) begin
    if (sys_rst || !running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 0 decode; all flags are gated off while idle because the parked counters sit in the sync region
  always_comb begin
    hs_c  = running && (h_cnt < H_SYNC_END);
    vs_c  = running && (v_cnt < V_SYNC_END);
    act_c = running && (h_cnt >= H_ACT0) && (h_cnt < H_ACT1) &&
            (v_cnt >= V_ACT0) && (v_cnt < V_ACT1);
    fs_c  = running && (h_cnt == '0) && (v_cnt == '0);
  end

  // Stage 1: request coordinates for the pattern source plus the matching flags
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      pix_x <= PIX_NONE;
      pix_y <= PIX_NONE;
      act_1 <= 1'b0;
      hs_1  <= 1'b0;
      vs_1  <= 1'b0;
      fs_1  <= 1'b0;
    end else begin
      pix_x <= act_c ? PIX_W'(h_cnt - H_ACT0) : PIX_NONE;
      pix_y <= act_c ? PIX_W'(v_cnt - V_ACT0) : PIX_NONE;
      act_1 <= act_c;
      hs_1  <= hs_c;
      vs_1  <= vs_c;
      fs_1  <= fs_c;
    end
  end

  lcd_sync_delay #(
    .DEPTH (PIC_LAT),
    .WIDTH (4)
  ) u_sync_delay (
    .clk_in  (clk_in),
    .sys_rst (sys_rst),
    .din     ({act_1, hs_1, vs_1, fs_1}),
    .dout    ({act_d, hs_d, vs_d, fs_d})
  );

  // Output stage: source pixel captured only inside the active window, syncs mapped to panel polarity
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      lcd_rgb     <= '0;
      lcd_de      <= 1'b0;
      lcd_hs      <= SYNC_IDLE;
      lcd_vs      <= SYNC_IDLE;
      frame_start <= 1'b0;
    end else begin
      lcd_rgb     <= act_d ? pix_data : '0;
      lcd_de      <= act_d;
      lcd_hs      <= hs_d ? SYNC_POL : SYNC_IDLE;
      lcd_vs      <= vs_d ? SYNC_POL : SYNC_IDLE;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_lcd_timing_drv.sv
// tb/tb_lcd_timing_drv.sv - directed bench for lcd_timing_drv on a reduced 17x10 raster, two latency/polarity builds
module tb_lcd_timing_drv;

  localparam int HS = 4, HB = 3, HV = 8, HF = 2;
  localparam int VS = 2, VB = 2, VV = 5, VF = 1;
  localparam int K_END = 1300;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic sys_rst, lcd_en;

  logic [23:0] pix_data_a, pix_data_b, lcd_rgb_a, lcd_rgb_b;
  logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
  logic        lcd_hs_a, lcd_vs_a, lcd_de_a, fs_a, busy_a;
  logic        lcd_hs_b, lcd_vs_b, lcd_de_b, fs_b, busy_b;
  logic [23:0] src_b [2];

  lcd_timing_drv #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .PIC_LAT(1), .SYNC_POL(1'b0)
  ) dut_a (
    .clk_in(clk_in), .sys_rst(sys_rst), .lcd_en(lcd_en), .pix_data(pix_data_a),
    .pix_x(pix_x_a), .pix_y(pix_y_a), .lcd_hs(lcd_hs_a), .lcd_vs(lcd_vs_a),
    .lcd_de(lcd_de_a), .lcd_rgb(lcd_rgb_a), .frame_start(fs_a), .busy(busy_a)
  );

  lcd_timing_drv #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .PIC_LAT(3), .SYNC_POL(1'b1)
  ) dut_b (
    .clk_in(clk_in), .sys_rst(sys_rst), .lcd_en(lcd_en), .pix_data(pix_data_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .lcd_hs(lcd_hs_b), .lcd_vs(lcd_vs_b),
    .lcd_de(lcd_de_b), .lcd_rgb(lcd_rgb_b), .frame_start(fs_b), .busy(busy_b)
  );

  // Pattern sources: echo coordinates with 1 and 3 clocks of latency
  always_ff @(posedge clk_in) begin
    pix_data_a <= {pix_y_a[7:0], 6'b0, pix_x_a};
    src_b[0]   <= {pix_y_b[7:0], 6'b0, pix_x_b};
    src_b[1]   <= src_b[0];
    pix_data_b <= src_b[1];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int exp_fs   [8] = '{4, 174, 344, 604, 774, 944, 1058, 1228};
  int exp_de_a [8] = '{0, 40, 40, 40, 40, 40, 17, 40};
  int exp_de_b [8] = '{0, 40, 40, 40, 40, 40, 16, 40};

  int fs_t [2][16];
  int de_f [2][16];
  int hsa_f[2][16];
  int vsa_f[2][16];
  int nfs[2], de_cnt[2], hsa_cnt[2], vsa_cnt[2];
  int de_run[2], bad_run[2], pix_err[2], zero_err[2], first_de[2], ex[2], ey[2];
  logic [23:0] first_px[2], last_px1[2];
  logic        s_de[2], s_hs[2], s_vs[2], s_fs[2];
  logic [23:0] s_rgb[2];
  logic [23:0] e_px;

  initial begin
    for (int i = 0; i < 2; i++) begin
      nfs[i] = 0; de_cnt[i] = 0; hsa_cnt[i] = 0; vsa_cnt[i] = 0;
      de_run[i] = 0; bad_run[i] = 0; pix_err[i] = 0; zero_err[i] = 0;
      first_de[i] = -1; ex[i] = 0; ey[i] = 0; first_px[i] = '0; last_px1[i] = '0;
    end
    sys_rst = 1'b1;
    lcd_en  = 1'b0;
    repeat (3) @(negedge clk_in);
    check_val("rst_pix_x",  32'(pix_x_a), 32'h3FF);
    check_val("rst_pix_y",  32'(pix_y_a), 32'h3FF);
    check_val("rst_hs_a",   32'(lcd_hs_a), 32'd1);
    check_val("rst_vs_a",   32'(lcd_vs_a), 32'd1);
    check_val("rst_hs_b",   32'(lcd_hs_b), 32'd0);
    check_val("rst_vs_b",   32'(lcd_vs_b), 32'd0);
    check_val("rst_de",     32'(lcd_de_a), 32'd0);
    check_val("rst_rgb",    32'(lcd_rgb_a), 32'd0);
    check_val("rst_fs",     32'(fs_a), 32'd0);
    check_val("rst_busy",   32'(busy_a), 32'd0);
    sys_rst = 1'b0;
    lcd_en  = 1'b1;

    for (int k = 1; k <= K_END; k++) begin
      @(negedge clk_in);
      s_de[0] = lcd_de_a; s_rgb[0] = lcd_rgb_a; s_fs[0] = fs_a;
      s_hs[0] = (lcd_hs_a == 1'b0); s_vs[0] = (lcd_vs_a == 1'b0);
      s_de[1] = lcd_de_b; s_rgb[1] = lcd_rgb_b; s_fs[1] = fs_b;
      s_hs[1] = (lcd_hs_b == 1'b1); s_vs[1] = (lcd_vs_b == 1'b1);

      for (int i = 0; i < 2; i++) begin
        if (s_fs[i]) begin
          if (nfs[i] < 16) begin
            fs_t[i][nfs[i]]  = k;
            de_f[i][nfs[i]]  = de_cnt[i];
            hsa_f[i][nfs[i]] = hsa_cnt[i];
            vsa_f[i][nfs[i]] = vsa_cnt[i];
          end
          nfs[i]++;
          de_cnt[i] = 0; hsa_cnt[i] = 0; vsa_cnt[i] = 0; ex[i] = 0; ey[i] = 0;
        end
        if (s_hs[i]) hsa_cnt[i]++;
        if (s_vs[i]) vsa_cnt[i]++;
        if (s_de[i]) begin
          de_cnt[i]++;
          de_run[i]++;
          if (first_de[i] < 0) begin
            first_de[i] = k;
            first_px[i] = s_rgb[i];
          end
          if (nfs[i] == 1) last_px1[i] = s_rgb[i];
          e_px = {8'(ey[i]), 6'b0, 10'(ex[i])};
          if (s_rgb[i] !== e_px) pix_err[i]++;
          ex[i]++;
          if (ex[i] == HV) begin
            ex[i] = 0;
            ey[i] = (ey[i] == VV - 1) ? 0 : ey[i] + 1;
          end
        end else begin
          if (s_rgb[i] !== 24'd0) zero_err[i]++;
          if (de_run[i] != 0 && k < 1050 && de_run[i] != HV) bad_run[i]++;
          de_run[i] = 0;
        end
      end

      if (k == 510) begin
        check_val("busy_last_frame_cycle_a", 32'(busy_a), 32'd1);
        check_val("busy_last_frame_cycle_b", 32'(busy_b), 32'd1);
      end
      if (k == 511) begin
        check_val("busy_after_stop_a", 32'(busy_a), 32'd0);
        check_val("busy_after_stop_b", 32'(busy_b), 32'd0);
      end
      if (k == 520) begin
        check_val("idle_hs_a",  32'(lcd_hs_a), 32'd1);
        check_val("idle_vs_a",  32'(lcd_vs_a), 32'd1);
        check_val("idle_hs_b",  32'(lcd_hs_b), 32'd0);
        check_val("idle_de_b",  32'(lcd_de_b), 32'd0);
        check_val("idle_rgb_a", 32'(lcd_rgb_a), 32'd0);
        check_val("idle_pix_x", 32'(pix_x_a), 32'h3FF);
      end
      if (k == 1054) begin
        check_val("midrst_de_a",    32'(lcd_de_a), 32'd0);
        check_val("midrst_pix_x_a", 32'(pix_x_a), 32'h3FF);
        check_val("midrst_pix_y_b", 32'(pix_y_b), 32'h3FF);
        check_val("midrst_busy",    32'(busy_a), 32'd0);
        check_val("midrst_hs_a",    32'(lcd_hs_a), 32'd1);
      end

      if (k == 426)  lcd_en = 1'b0;
      if (k == 600)  lcd_en = 1'b1;
      if (k == 650)  lcd_en = 1'b0;
      if (k == 700)  lcd_en = 1'b1;
      if (k == 1053) sys_rst = 1'b1;
      if (k == 1054) sys_rst = 1'b0;
    end

    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("fs_count_%0d", i), 32'(nfs[i]), 32'd8);
      for (int j = 0; j < 8; j++) begin
        check_val($sformatf("fs_time_%0d_%0d", i, j), 32'(fs_t[i][j]), 32'(exp_fs[j] + 2 * i));
        check_val($sformatf("de_per_frame_%0d_%0d", i, j), 32'(de_f[i][j]),
                  32'(i == 0 ? exp_de_a[j] : exp_de_b[j]));
      end
      check_val($sformatf("hs_active_f1_%0d", i), 32'(hsa_f[i][2]), 32'd40);
      check_val($sformatf("vs_active_f1_%0d", i), 32'(vsa_f[i][2]), 32'd34);
      check_val($sformatf("hs_active_f3_%0d", i), 32'(hsa_f[i][4]), 32'd40);
      check_val($sformatf("vs_active_f3_%0d", i), 32'(vsa_f[i][4]), 32'd34);
      check_val($sformatf("first_de_time_%0d", i), 32'(first_de[i]), 32'(79 + 2 * i));
      check_val($sformatf("first_pixel_%0d", i), 32'(first_px[i]), 32'h000000);
      check_val($sformatf("last_pixel_%0d", i), 32'(last_px1[i]), 32'h040007);
      check_val($sformatf("pixel_errors_%0d", i), 32'(pix_err[i]), 32'd0);
      check_val($sformatf("rgb_outside_de_%0d", i), 32'(zero_err[i]), 32'd0);
      check_val($sformatf("bad_de_runs_%0d", i), 32'(bad_run[i]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
